dirsq_arbiter: RTL and testbench

DIRSQ_ARBITER -- requirements
Module: dirsq_arbiter

---
 rtl/dirsq_arbiter_pkg.sv | 22 ++
 rtl/dirsq_arbiter_rr_arbiter.sv | 30 +++
 rtl/dirsq_arbiter_square.sv | 43 ++++
 rtl/dirsq_arbiter.sv | 117 +++++++++++
 tb/tb_dirsq_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dirsq_arbiter_pkg.sv
// Shared ray-direction types and fixed-point format for the direction-square arbiter slice.
package dirsq_arbiter_pkg;

    localparam int WIDTH  = 16;
    localparam int Q_BITS = 8;

    typedef struct packed {
        logic signed [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] y;
        logic signed [WIDTH-1:0] z;
    } RayDirection;

    typedef struct packed {
        logic signed [WIDTH-1:0]   x;
        logic signed [WIDTH-1:0]   y;
        logic signed [WIDTH-1:0]   z;
        logic signed [2*WIDTH-1:0] x_sqr;
        logic signed [2*WIDTH-1:0] y_sqr;
        logic signed [2*WIDTH-1:0] z_sqr;
    } RayDirection_sqr;

endpackage

// File: rtl/dirsq_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: searches upward starting one past the pointer, wrapping at N.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int          PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic             enable,
    input  logic [PTR_W-1:0] pointer,
    output logic [N-1:0]     grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (enable) begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = (32'(pointer) + k) % N;
                if (!found && req[PTR_W'(idx)]) begin
                    grant[PTR_W'(idx)] = 1'b1;
                    found              = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dirsq_arbiter_square.sv
// Single-cycle direction squarer: registers the components and their full-width signed squares.
module direction_square
    import dirsq_arbiter_pkg::*;
#(
    parameter int WIDTH  = dirsq_arbiter_pkg::WIDTH,
    parameter int Q_BITS = dirsq_arbiter_pkg::Q_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  RayDirection     RDS_in,
    output logic            valid,
    output RayDirection_sqr RDS_out
);

    // The binary point only moves (Q -> 2Q); the integer product is format-agnostic.
    if (Q_BITS >= WIDTH) begin : g_no_integer_bits
    end

    function automatic logic signed [2*WIDTH-1:0] square(input logic signed [WIDTH-1:0] v);
        logic signed [2*WIDTH-1:0] w;
        w = {{WIDTH{v[WIDTH-1]}}, v};
        return w * w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            RDS_out <= '0;
        end else begin
            valid <= start;
            if (start) begin
                RDS_out.x     <= RDS_in.x;
                RDS_out.y     <= RDS_in.y;
                RDS_out.z     <= RDS_in.z;
                RDS_out.x_sqr <= square(RDS_in.x);
                RDS_out.y_sqr <= square(RDS_in.y);
                RDS_out.z_sqr <= square(RDS_in.z);
            end
        end
    end

endmodule

// File: rtl/dirsq_arbiter.sv
// Time-shares one direction squarer among N_REQ requesters; results return in issue order via a 2-entry FIFO.
module dirsq_arbiter
    import dirsq_arbiter_pkg::*;
#(
    parameter  int          WIDTH  = dirsq_arbiter_pkg::WIDTH,
    parameter  int          Q_BITS = dirsq_arbiter_pkg::Q_BITS,
    parameter  int unsigned N_REQ  = 4,
    localparam int          ID_W   = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic        [N_REQ-1:0]       req_valid,
    input  RayDirection [N_REQ-1:0]       req_dir,
    output logic        [N_REQ-1:0]       req_ready,
    output logic                          res_valid,
    output RayDirection_sqr               res_data,
    output logic        [ID_W-1:0]        res_id,
    input  logic                          res_ready
);

    typedef struct packed {
        RayDirection_sqr data;
        logic [ID_W-1:0] id;
    } entry_t;

    entry_t          fifo_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      fifo_count;
    logic            inflight;
    logic [ID_W-1:0] inflight_id;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic [N_REQ-1:0] grant;
    logic [2:0]      occupancy;
    logic            pop;
    logic            issue;
    logic            enable;
    logic            sq_valid;
    RayDirection     sq_in;
    RayDirection_sqr sq_out;

    assign res_valid = (fifo_count != 2'd0);
    assign pop       = res_valid & res_ready;
    // Credits count everything issued but not yet consumed; a same-cycle pop frees a slot.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign enable    = rst_n & (occupancy < 3'd2);
    assign req_ready = grant;
    assign issue     = |grant;
    assign res_data  = fifo_mem[rd_ptr].data;
    assign res_id    = fifo_mem[rd_ptr].id;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req     (req_valid),
        .enable  (enable),
        .pointer (last_grant),
        .grant   (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
        sq_in = req_dir[grant_id];
    end

    direction_square #(
        .WIDTH  (WIDTH),
        .Q_BITS (Q_BITS)
    ) u_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (issue),
        .RDS_in  (sq_in),
        .valid   (sq_valid),
        .RDS_out (sq_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_id <= '0;
            last_grant  <= ID_W'(N_REQ - 1);
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_id <= grant_id;
                last_grant  <= grant_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (sq_valid) begin
                fifo_mem[wr_ptr] <= '{data: sq_out, id: inflight_id};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({sq_valid, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dirsq_arbiter.sv
// Randomized bench for dirsq_arbiter against a queue-based, cycle-stamped behavioural model.
module tb_dirsq_arbiter;
    import dirsq_arbiter_pkg::*;

    localparam int N = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           req_valid;
    RayDirection [N-1:0]    req_dir;
    logic [N-1:0]           req_ready;
    logic                   res_valid;
    RayDirection_sqr        res_data;
    logic [1:0]             res_id;
    logic                   res_ready;

    always #5 clk = ~clk;

    dirsq_arbiter #(
        .WIDTH  (WIDTH),
        .Q_BITS (Q_BITS),
        .N_REQ  (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    typedef struct {
        RayDirection_sqr d;
        int              id;
        int              due;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc;
    int           m_last;
    int           exp_idx;
    logic         exp_valid;
    logic         exp_pop;
    logic [N-1:0] exp_grant;
    logic [N-1:0] pend;
    RayDirection  pend_dir [N];
    int           p_valid;
    int           p_ready;
    logic [N-1:0] mask;
    int           gcnt [N];
    int           n_pass;
    int           n_checks;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] rand_comp();
        case ($urandom_range(7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    function automatic RayDirection rand_dir();
        RayDirection d;
        d.x = rand_comp();
        d.y = rand_comp();
        d.z = rand_comp();
        return d;
    endfunction

    function automatic RayDirection_sqr model_square(input RayDirection d);
        RayDirection_sqr r;
        int vx, vy, vz;
        vx = $signed(d.x);
        vy = $signed(d.y);
        vz = $signed(d.z);
        r.x = d.x;
        r.y = d.y;
        r.z = d.z;
        r.x_sqr = vx * vx;
        r.y_sqr = vy * vy;
        r.z_sqr = vz * vz;
        return r;
    endfunction

    task automatic cycle_begin();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && $urandom_range(99) < p_valid) begin
                pend[i]     = 1'b1;
                pend_dir[i] = rand_dir();
            end
            req_dir[i] = pend[i] ? pend_dir[i] : rand_dir();
        end
        req_valid = pend;
        res_ready = ($urandom_range(99) < p_ready);
        #3;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        exp_pop   = exp_valid && res_ready;
        exp_idx   = -1;
        if (exp_q.size() - int'(exp_pop) < 2) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (exp_idx < 0 && pend[c]) exp_idx = c;
            end
        end
        exp_grant = '0;
        if (exp_idx >= 0) exp_grant[exp_idx] = 1'b1;
        check_eq("req_ready", req_ready, exp_grant);
        check_eq("res_valid", res_valid, exp_valid);
        if (exp_valid) begin
            check_eq("res_data", res_data, exp_q[0].d);
            check_eq("res_id", res_id, exp_q[0].id);
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) gcnt[i]++;
    endtask

    task automatic cycle_end();
        if (exp_pop) void'(exp_q.pop_front());
        if (exp_idx >= 0) begin
            exp_q.push_back('{model_square(pend_dir[exp_idx]), exp_idx, cyc + 2});
            m_last        = exp_idx;
            pend[exp_idx] = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        cycle_begin();
        cycle_end();
    endtask

    task automatic run(input int n, input int pv, input int pr, input logic [N-1:0] m);
        p_valid = pv;
        p_ready = pr;
        mask    = m;
        repeat (n) cycle();
    endtask

    task automatic drain();
        run(8, 0, 100, '0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    task automatic check_reset_outputs(input string phase);
        check_eq({phase, "_req_ready"}, req_ready, '0);
        check_eq({phase, "_res_valid"}, res_valid, 1'b0);
        check_eq({phase, "_res_data"}, res_data, '0);
        check_eq({phase, "_res_id"}, res_id, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RayDirection     d;
        RayDirection_sqr e;
        logic [N-1:0]    lowest;
        int              total;

        n_pass = 0; n_checks = 0; cyc = 0; m_last = N - 1;
        pend = '0; mask = '0; p_valid = 0; p_ready = 100;
        for (int i = 0; i < N; i++) pend_dir[i] = '0;
        clear_counts();
        rst_n = 1'b0; res_ready = 1'b0; req_valid = '1; req_dir = '0;
        #2;
        check_reset_outputs("reset");
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2 with a known vector.
        d.x = 3; d.y = -4; d.z = 5;
        pend[2] = 1'b1; pend_dir[2] = d;
        p_valid = 0; p_ready = 100; mask = '0;
        cycle_begin();
        check_eq("single_grant", req_ready, 4'b0100);
        cycle_end();
        cycle();
        cycle_begin();
        e.x = 3; e.y = -4; e.z = 5; e.x_sqr = 9; e.y_sqr = 16; e.z_sqr = 25;
        check_eq("single_res_valid", res_valid, 1'b1);
        check_eq("single_res_data", res_data, e);
        check_eq("single_res_id", res_id, 2'd2);
        cycle_end();
        drain();

        run(200, 50, 70, '1);
        run(200, 100, 100, '1);
        run(200, 30, 30, '1);
        drain();

        // Backpressure: only two issues fit before the consumer drains.
        clear_counts();
        run(6, 100, 0, '1);
        total = 0;
        for (int i = 0; i < N; i++) total += gcnt[i];
        check_eq("bp_issue_count", total, 2);
        run(10, 100, 100, '1);
        drain();

        // Fairness between requesters 1 and 3 starting with last grant = 1.
        pend[1] = 1'b1; pend_dir[1] = rand_dir();
        run(1, 0, 100, '0);
        clear_counts();
        run(100, 100, 100, 4'b1010);
        check_eq("fair_cnt1", gcnt[1], 50);
        check_eq("fair_cnt3", gcnt[3], 50);
        drain();

        // Reset with one result buffered and one in flight.
        run(2, 100, 0, '1);
        cycle_begin();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_last = N - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p_ready = 100;
        cycle_begin();
        lowest = '0;
        for (int i = N - 1; i >= 0; i--) if (req_valid[i]) lowest = N'(1) << i;
        check_eq("first_grant_after_reset", req_ready, lowest);
        cycle_end();
        run(100, 60, 80, '1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
